// File: rtl/hazard_ctrl.sv
// Hazard unit for a five-stage pipeline: a scoreboard of E/M/W producers derives stall,
// bubble and forwarding selects from Tuse/Tnew, and counts stalled cycles.
module hazard_ctrl #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       d_rs,
    input  logic [4:0]       d_rt,
    input  logic [1:0]       d_tuse_rs,
    input  logic [1:0]       d_tuse_rt,
    input  logic             d_wr,
    input  logic [4:0]       d_waddr,
    input  logic [1:0]       d_tnew,
    output logic             stall,
    output logic             bubble_e,
    output logic [1:0]       fwd_d_rs,
    output logic [1:0]       fwd_d_rt,
    output logic [1:0]       fwd_e_rs,
    output logic [1:0]       fwd_e_rt,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int unsigned REG_W = 5;
    localparam int unsigned T_W   = 2;

    localparam logic [1:0] TUSE_NONE = 2'd3;
    localparam logic [1:0] SRC_RF    = 2'b00;
    localparam logic [1:0] SRC_W     = 2'b01;
    localparam logic [1:0] SRC_M     = 2'b10;
    localparam logic [1:0] SRC_E     = 2'b11;

    logic             e_vld, m_vld, w_vld;
    logic [REG_W-1:0] e_waddr, m_waddr, w_waddr;
    logic [T_W-1:0]   e_tnew, m_tnew, w_tnew;
    logic [REG_W-1:0] e_rs, e_rt;

    function automatic logic hit(input logic vld, input logic [REG_W-1:0] waddr,
                                 input logic [REG_W-1:0] r);
        return vld && (waddr == r) && (r != REG_W'(0));
    endfunction

    function automatic logic [T_W-1:0] dec_sat(input logic [T_W-1:0] t);
        return (t == T_W'(0)) ? T_W'(0) : T_W'(t - T_W'(1));
    endfunction

    // Youngest producer among E then M decides whether the operand arrives too late.
    function automatic logic need_stall(input logic [REG_W-1:0] r, input logic [T_W-1:0] tuse,
                                        input logic ev, input logic [REG_W-1:0] ea,
                                        input logic [T_W-1:0] et,
                                        input logic mv, input logic [REG_W-1:0] ma,
                                        input logic [T_W-1:0] mt);
        logic res;
        res = 1'b0;
        if (tuse != TUSE_NONE) begin
            if (hit(ev, ea, r))      res = (et > tuse);
            else if (hit(mv, ma, r)) res = (mt > tuse);
        end
        return res;
    endfunction

    function automatic logic [1:0] sel_d(input logic [REG_W-1:0] r, input logic [T_W-1:0] tuse,
                                         input logic ev, input logic [REG_W-1:0] ea,
                                         input logic [T_W-1:0] et,
                                         input logic mv, input logic [REG_W-1:0] ma,
                                         input logic [T_W-1:0] mt,
                                         input logic wv, input logic [REG_W-1:0] wa,
                                         input logic [T_W-1:0] wt);
        logic [1:0] src;
        src = SRC_RF;
        if (tuse != TUSE_NONE) begin
            if (hit(ev, ea, r))      src = (et == T_W'(0)) ? SRC_E : SRC_RF;
            else if (hit(mv, ma, r)) src = (mt == T_W'(0)) ? SRC_M : SRC_RF;
            else if (hit(wv, wa, r)) src = (wt == T_W'(0)) ? SRC_W : SRC_RF;
        end
        return src;
    endfunction

    function automatic logic [1:0] sel_e(input logic [REG_W-1:0] r,
                                         input logic mv, input logic [REG_W-1:0] ma,
                                         input logic [T_W-1:0] mt,
                                         input logic wv, input logic [REG_W-1:0] wa,
                                         input logic [T_W-1:0] wt);
        logic [1:0] src;
        src = SRC_RF;
        if (hit(mv, ma, r))      src = (mt == T_W'(0)) ? SRC_M : SRC_RF;
        else if (hit(wv, wa, r)) src = (wt == T_W'(0)) ? SRC_W : SRC_RF;
        return src;
    endfunction

    always_comb begin
        stall    = need_stall(d_rs, d_tuse_rs, e_vld, e_waddr, e_tnew, m_vld, m_waddr, m_tnew)
                 | need_stall(d_rt, d_tuse_rt, e_vld, e_waddr, e_tnew, m_vld, m_waddr, m_tnew);
        bubble_e = stall;
        fwd_d_rs = sel_d(d_rs, d_tuse_rs, e_vld, e_waddr, e_tnew, m_vld, m_waddr, m_tnew,
                         w_vld, w_waddr, w_tnew);
        fwd_d_rt = sel_d(d_rt, d_tuse_rt, e_vld, e_waddr, e_tnew, m_vld, m_waddr, m_tnew,
                         w_vld, w_waddr, w_tnew);
        fwd_e_rs = sel_e(e_rs, m_vld, m_waddr, m_tnew, w_vld, w_waddr, w_tnew);
        fwd_e_rt = sel_e(e_rt, m_vld, m_waddr, m_tnew, w_vld, w_waddr, w_tnew);
    end

    // Scoreboard shift; a stall injects an empty slot into E while M and W drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_vld   <= 1'b0;
            e_waddr <= '0;
            e_tnew  <= '0;
            e_rs    <= '0;
            e_rt    <= '0;
            m_vld   <= 1'b0;
            m_waddr <= '0;
            m_tnew  <= '0;
            w_vld   <= 1'b0;
            w_waddr <= '0;
            w_tnew  <= '0;
        end else begin
            if (stall) begin
                e_vld   <= 1'b0;
                e_waddr <= '0;
                e_tnew  <= '0;
                e_rs    <= '0;
                e_rt    <= '0;
            end else begin
                e_vld   <= d_wr;
                e_waddr <= d_waddr;
                e_tnew  <= d_tnew;
                e_rs    <= d_rs;
                e_rt    <= d_rt;
            end
            m_vld   <= e_vld;
            m_waddr <= e_waddr;
            m_tnew  <= dec_sat(e_tnew);
            w_vld   <= m_vld;
            w_waddr <= m_waddr;
            w_tnew  <= dec_sat(m_tnew);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a per-cycle instruction stream with hand-computed
// expected selects, then reset-during-stall and counter saturation sequences.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] d_rs, d_rt, d_waddr;
    logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
    logic       d_wr;
    logic       stall, bubble_e;
    logic [1:0] fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt;
    logic [15:0] stall_cnt;
    logic       stall2, bubble2;
    logic [1:0] f2a, f2b, f2c, f2d;
    logic [1:0] cnt2;

    int checks = 0;
    int errors = 0;

    hazard_ctrl dut (
        .clk(clk), .rst_n(rst_n), .d_rs(d_rs), .d_rt(d_rt),
        .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt), .d_wr(d_wr),
        .d_waddr(d_waddr), .d_tnew(d_tnew), .stall(stall), .bubble_e(bubble_e),
        .fwd_d_rs(fwd_d_rs), .fwd_d_rt(fwd_d_rt), .fwd_e_rs(fwd_e_rs),
        .fwd_e_rt(fwd_e_rt), .stall_cnt(stall_cnt)
    );

    hazard_ctrl #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .d_rs(d_rs), .d_rt(d_rt),
        .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt), .d_wr(d_wr),
        .d_waddr(d_waddr), .d_tnew(d_tnew), .stall(stall2), .bubble_e(bubble2),
        .fwd_d_rs(f2a), .fwd_d_rt(f2b), .fwd_e_rs(f2c),
        .fwd_e_rt(f2d), .stall_cnt(cnt2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] rs, rt;
        logic [1:0] tuse_rs, tuse_rt;
        logic       wr;
        logic [4:0] waddr;
        logic [1:0] tnew;
        logic       stall;
        logic [1:0] fdrs, fdrt, fers, fert;
    } vec_t;

    localparam int NV = 28;
    vec_t tbl [NV];

    function automatic vec_t mk(input int rs, input int rt, input int trs, input int trt,
                                input int wr, input int wa, input int tn, input int st,
                                input int fdrs, input int fdrt, input int fers, input int fert);
        vec_t v;
        v.rs = 5'(rs); v.rt = 5'(rt); v.tuse_rs = 2'(trs); v.tuse_rt = 2'(trt);
        v.wr = 1'(wr); v.waddr = 5'(wa); v.tnew = 2'(tn); v.stall = 1'(st);
        v.fdrs = 2'(fdrs); v.fdrt = 2'(fdrt); v.fers = 2'(fers); v.fert = 2'(fert);
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s [%0d] got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic [1:0] trs,
                         input logic [1:0] trt, input logic wr, input logic [4:0] wa,
                         input logic [1:0] tn);
        d_rs = rs; d_rt = rt; d_tuse_rs = trs; d_tuse_rt = trt;
        d_wr = wr; d_waddr = wa; d_tnew = tn;
    endtask

    task automatic chk_outs(input string tag, input int idx, input logic st,
                            input logic [1:0] fdrs, input logic [1:0] fdrt,
                            input logic [1:0] fers, input logic [1:0] fert);
        chk({tag, ".stall"}, idx, 32'(stall), 32'(st));
        chk({tag, ".bubble_e"}, idx, 32'(bubble_e), 32'(st));
        chk({tag, ".fwd_d_rs"}, idx, 32'(fwd_d_rs), 32'(fdrs));
        chk({tag, ".fwd_d_rt"}, idx, 32'(fwd_d_rt), 32'(fdrt));
        chk({tag, ".fwd_e_rs"}, idx, 32'(fwd_e_rs), 32'(fers));
        chk({tag, ".fwd_e_rt"}, idx, 32'(fwd_e_rt), 32'(fert));
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // rs, rt, tuse_rs, tuse_rt, wr, waddr, tnew | stall, fd_rs, fd_rt, fe_rs, fe_rt
        tbl[0]  = mk(29, 0, 1, 3, 1,  8, 2,  0, 0, 0, 0, 0); // lw $8
        tbl[1]  = mk( 8,10, 1, 1, 1,  9, 1,  1, 0, 0, 0, 0); // addu $9,$8,$10: load-use
        tbl[2]  = mk( 8,10, 1, 1, 1,  9, 1,  0, 0, 0, 0, 0);
        tbl[3]  = mk( 0, 0, 3, 3, 0,  0, 0,  0, 0, 0, 1, 0); // addu in E takes $8 from W
        tbl[4]  = mk( 1, 2, 1, 1, 1,  4, 1,  0, 0, 0, 0, 0); // addu $4
        tbl[5]  = mk( 4, 5, 0, 0, 0,  0, 0,  1, 0, 0, 0, 0); // beq $4,$5
        tbl[6]  = mk( 4, 5, 0, 0, 0,  0, 0,  0, 2, 0, 0, 0);
        tbl[7]  = mk( 0, 0, 3, 3, 1, 31, 0,  0, 0, 0, 1, 0); // jal
        tbl[8]  = mk(31, 0, 0, 3, 0,  0, 0,  0, 3, 0, 0, 0); // jr $31
        tbl[9]  = mk(29, 0, 1, 3, 1,  0, 2,  0, 0, 0, 2, 0); // lw $0
        tbl[10] = mk( 0, 0, 1, 1, 1,  1, 1,  0, 0, 0, 0, 0); // addu $1,$0,$0
        tbl[11] = mk(29, 0, 1, 3, 1,  3, 2,  0, 0, 0, 0, 0); // lw $3
        tbl[12] = mk( 0, 0, 3, 3, 0,  0, 0,  0, 0, 0, 0, 0);
        tbl[13] = mk( 5, 6, 1, 1, 1,  3, 1,  0, 0, 0, 0, 0); // addu $3,$5,$6
        tbl[14] = mk( 3, 0, 1, 1, 1,  7, 1,  0, 0, 0, 0, 0); // E (not ready) shadows W
        tbl[15] = mk( 0, 0, 3, 3, 0,  0, 0,  0, 0, 0, 2, 0);
        tbl[16] = mk( 0, 0, 3, 3, 1,  7, 0,  0, 0, 0, 0, 0); // tnew-0 producer of $7
        tbl[17] = mk( 7, 3, 0, 0, 0,  0, 0,  0, 3, 0, 0, 0); // E and W both hold $7
        tbl[18] = mk( 0, 0, 3, 3, 0,  0, 0,  0, 0, 0, 2, 0);
        tbl[19] = mk(29, 0, 1, 3, 1, 12, 2,  0, 0, 0, 0, 0); // lw $12
        tbl[20] = mk(29,12, 1, 2, 0,  0, 0,  0, 0, 0, 0, 0); // sw: tuse_rt 2 == tnew 2
        tbl[21] = mk( 0, 0, 3, 3, 0,  0, 0,  0, 0, 0, 0, 0); // M tnew 1 not forwarded to E
        tbl[22] = mk(12,12, 0, 0, 0,  0, 0,  0, 1, 1, 0, 0);
        tbl[23] = mk( 0, 0, 1, 3, 1, 13, 2,  0, 0, 0, 0, 0); // lw $13
        tbl[24] = mk( 0,13, 1, 1, 1, 14, 1,  1, 0, 0, 0, 0); // rt load-use
        tbl[25] = mk( 0,13, 1, 1, 1, 14, 1,  0, 0, 0, 0, 0);
        tbl[26] = mk( 0, 0, 3, 3, 0,  0, 0,  0, 0, 0, 0, 1);
        tbl[27] = mk(14,14, 3, 1, 0,  0, 0,  0, 0, 2, 0, 0); // unused rs stays 00

        rst_n = 1'b0;
        drive(5'd0, 5'd0, 2'd3, 2'd3, 1'b0, 5'd0, 2'd0);
        #2;
        chk_outs("reset", 0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0);
        chk("reset.stall_cnt", 0, 32'(stall_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();

        for (int i = 0; i < NV; i++) begin
            drive(tbl[i].rs, tbl[i].rt, tbl[i].tuse_rs, tbl[i].tuse_rt,
                  tbl[i].wr, tbl[i].waddr, tbl[i].tnew);
            #1;
            chk_outs("vec", i, tbl[i].stall, tbl[i].fdrs, tbl[i].fdrt,
                     tbl[i].fers, tbl[i].fert);
            if (i == 3) chk("vec.stall_cnt", i, 32'(stall_cnt), 32'd1);
            next_cycle();
        end
        chk("stream.stall_cnt", 0, 32'(stall_cnt), 32'd3);
        chk("stream.cnt_w2", 0, 32'(cnt2), 32'd3);

        // Saturation of the narrow counter on one more load-use stall
        drive(5'd29, 5'd0, 2'd1, 2'd3, 1'b1, 5'd8, 2'd2);
        next_cycle();
        drive(5'd8, 5'd10, 2'd1, 2'd1, 1'b1, 5'd9, 2'd1);
        #1;
        chk("sat.stall", 0, 32'(stall), 32'd1);
        next_cycle();
        chk("sat.stall_after", 0, 32'(stall), 32'd0);
        chk("sat.stall_cnt", 0, 32'(stall_cnt), 32'd4);
        chk("sat.cnt_w2", 0, 32'(cnt2), 32'd3);
        next_cycle();

        // Reset asserted in the middle of a stall cycle
        drive(5'd29, 5'd0, 2'd1, 2'd3, 1'b1, 5'd8, 2'd2);
        next_cycle();
        drive(5'd8, 5'd10, 2'd1, 2'd1, 1'b1, 5'd9, 2'd1);
        #1;
        chk("rst.stall_before", 0, 32'(stall), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk_outs("rst.during", 0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0);
        chk("rst.stall_cnt", 0, 32'(stall_cnt), 32'd0);
        chk("rst.cnt_w2", 0, 32'(cnt2), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();
        #1;
        chk_outs("rst.after", 0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0);
        next_cycle();
        chk("rst.cnt_after", 0, 32'(stall_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
